// File: rtl/ups_axi4l_pkg.sv
// Shared types and constants for the two-requester AXI4-Lite arbiter.
package ups_axi4l_pkg;

    localparam int unsigned AXI_W  = 32;
    localparam int unsigned STRB_W = AXI_W / 8;
    localparam int unsigned WDOG_W = 16;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE         = 3'd0,
        ST_RD_ADDR      = 3'd1,
        ST_RD_DATA      = 3'd2,
        ST_WR_ADDR_DATA = 3'd3,
        ST_WR_RESP      = 3'd4,
        ST_DONE         = 3'd5
    } state_e;

    // Request captured at grant time and held for the whole AXI transaction.
    typedef struct packed {
        logic              wr;
        logic [AXI_W-1:0]  addr;
        logic [AXI_W-1:0]  wdata;
        logic [STRB_W-1:0] wstrb;
    } req_t;

    // States in which the block is waiting on the AXI slave.
    function automatic logic is_axi_wait(state_e s);
        logic busy;
        busy = 1'b0;
        case (s)
            ST_RD_ADDR, ST_RD_DATA, ST_WR_ADDR_DATA, ST_WR_RESP: busy = 1'b1;
            default:                                             busy = 1'b0;
        endcase
        return busy;
    endfunction

endpackage

// File: rtl/ups_axi4l_arb_if.sv
// AXI4-Lite channel bundle; master side is the arbiter, slave side the memory/peripheral.
interface ups_axi4l_arb_if;
    import ups_axi4l_pkg::*;

    logic              ca4l_arvalid;
    logic              ca4l_arready;
    logic [AXI_W-1:0]  ca4l_araddr;
    logic [2:0]        ca4l_arprot;

    logic              ca4l_rvalid;
    logic              ca4l_rready;
    logic [AXI_W-1:0]  ca4l_rdata;
    logic [1:0]        ca4l_rresp;

    logic              ca4l_awvalid;
    logic              ca4l_awready;
    logic [AXI_W-1:0]  ca4l_awaddr;
    logic [2:0]        ca4l_awprot;

    logic              ca4l_wvalid;
    logic              ca4l_wready;
    logic [AXI_W-1:0]  ca4l_wdata;
    logic [STRB_W-1:0] ca4l_wstrb;

    logic              ca4l_bvalid;
    logic              ca4l_bready;
    logic [1:0]        ca4l_bresp;

    modport master (
        output ca4l_arvalid, ca4l_araddr, ca4l_arprot,
        input  ca4l_arready,
        input  ca4l_rvalid, ca4l_rdata, ca4l_rresp,
        output ca4l_rready,
        output ca4l_awvalid, ca4l_awaddr, ca4l_awprot,
        input  ca4l_awready,
        output ca4l_wvalid, ca4l_wdata, ca4l_wstrb,
        input  ca4l_wready,
        input  ca4l_bvalid, ca4l_bresp,
        output ca4l_bready
    );

    modport slave (
        input  ca4l_arvalid, ca4l_araddr, ca4l_arprot,
        output ca4l_arready,
        output ca4l_rvalid, ca4l_rdata, ca4l_rresp,
        input  ca4l_rready,
        input  ca4l_awvalid, ca4l_awaddr, ca4l_awprot,
        output ca4l_awready,
        input  ca4l_wvalid, ca4l_wdata, ca4l_wstrb,
        output ca4l_wready,
        output ca4l_bvalid, ca4l_bresp,
        input  ca4l_bready
    );

endinterface

// File: rtl/ups_rr_arb2.sv
// Two-way round-robin grant with the last-granted requester remembered.
module ups_rr_arb2 (
    input  logic       fclk,
    input  logic       rst_n,
    input  logic [1:0] req_valid,
    input  logic       grant_en,
    output logic [1:0] gnt_c,
    output logic       gnt_idx_c,
    output logic       last_grant
);

    logic last_grant_q;

    // On a tie the requester not served last wins; otherwise the sole requester wins.
    always_comb begin
        gnt_idx_c = 1'b0;
        gnt_c     = 2'b00;
        if (&req_valid) begin
            gnt_idx_c = ~last_grant_q;
        end else begin
            gnt_idx_c = req_valid[1];
        end
        if (|req_valid) begin
            gnt_c = gnt_idx_c ? 2'b10 : 2'b01;
        end
    end

    // Reset value 1 makes requester 0 win the first tie.
    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= 1'b1;
        end else if (grant_en && (|req_valid)) begin
            last_grant_q <= gnt_idx_c;
        end
    end

    assign last_grant = last_grant_q;

endmodule

// File: rtl/ups_axi4l_arb.sv
// Arbitrates two simple requesters onto one AXI4-Lite master, one transaction at a time.
module ups_axi4l_arb
    import ups_axi4l_pkg::*;
#(
    parameter logic [2:0]  AXI_PROT    = 3'b000,
    parameter int unsigned STALL_LIMIT = 1024
) (
    input  logic                   fclk,
    input  logic                   rst_n,
    input  logic [1:0]             req_valid,
    output logic [1:0]             req_ready,
    input  logic [1:0]             req_wr,
    input  logic [1:0][AXI_W-1:0]  req_addr,
    input  logic [1:0][AXI_W-1:0]  req_wdata,
    input  logic [1:0][STRB_W-1:0] req_wstrb,
    output logic [1:0]             rsp_valid,
    output logic [AXI_W-1:0]       rsp_rdata,
    output logic [1:0]             rsp_resp,
    output logic                   stall_err,
    ups_axi4l_arb_if.master        axi
);

    localparam logic [WDOG_W-1:0] WDOG_LIM = WDOG_W'(STALL_LIMIT);

    state_e            state_q, state_d;
    req_t              req_q, req_d;
    logic              arvalid_q, arvalid_d;
    logic              rready_q, rready_d;
    logic              awvalid_q, awvalid_d;
    logic              wvalid_q, wvalid_d;
    logic              bready_q, bready_d;
    logic [1:0]        req_ready_q, req_ready_d;
    logic [1:0]        rsp_valid_q, rsp_valid_d;
    logic [AXI_W-1:0]  rsp_rdata_q, rsp_rdata_d;
    logic [1:0]        rsp_resp_q, rsp_resp_d;
    logic              stall_q, stall_d;
    logic [WDOG_W-1:0] wdog_q, wdog_d;
    logic [WDOG_W-1:0] wdog_inc;
    logic              done;

    logic [1:0]        gnt_c;
    logic              gnt_idx_c;
    logic              last_grant;

    ups_rr_arb2 u_rr_arb2 (
        .fclk       (fclk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .grant_en   (state_q == ST_IDLE),
        .gnt_c      (gnt_c),
        .gnt_idx_c  (gnt_idx_c),
        .last_grant (last_grant)
    );

    // Next-state and next-output decode; every registered output gets its default first.
    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        req_ready_d = 2'b00;
        rsp_valid_d = 2'b00;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;
        stall_d     = stall_q;
        wdog_d      = wdog_q;
        wdog_inc    = wdog_q + WDOG_W'(1);
        done        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (|req_valid) begin
                    req_ready_d = gnt_c;
                    req_d.wr    = req_wr[gnt_idx_c];
                    req_d.addr  = req_addr[gnt_idx_c];
                    req_d.wdata = req_wdata[gnt_idx_c];
                    req_d.wstrb = req_wstrb[gnt_idx_c];
                    if (req_wr[gnt_idx_c]) begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = ST_WR_ADDR_DATA;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = ST_RD_ADDR;
                    end
                end
            end
            ST_RD_ADDR: begin
                if (axi.ca4l_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = ST_RD_DATA;
                end
            end
            ST_RD_DATA: begin
                if (axi.ca4l_rvalid) begin
                    rready_d = 1'b0;
                    done     = 1'b1;
                end
            end
            ST_WR_ADDR_DATA: begin
                // Address and data channels retire independently, possibly together.
                awvalid_d = awvalid_q & ~axi.ca4l_awready;
                wvalid_d  = wvalid_q & ~axi.ca4l_wready;
                if (!awvalid_d && !wvalid_d) begin
                    bready_d = 1'b1;
                    state_d  = ST_WR_RESP;
                end
            end
            ST_WR_RESP: begin
                if (axi.ca4l_bvalid) begin
                    bready_d = 1'b0;
                    done     = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Completion: response goes to whoever holds the grant; writes return zero data.
        if (done) begin
            state_d     = ST_DONE;
            rsp_valid_d = last_grant ? 2'b10 : 2'b01;
            rsp_rdata_d = req_q.wr ? '0 : axi.ca4l_rdata;
            rsp_resp_d  = req_q.wr ? axi.ca4l_bresp : axi.ca4l_rresp;
        end

        // Watchdog restarts on every state change and saturates at the limit; it only flags.
        if (state_d != state_q) begin
            wdog_d = '0;
        end else if (is_axi_wait(state_q) && (wdog_q != WDOG_LIM)) begin
            wdog_d = wdog_inc;
            if (wdog_inc == WDOG_LIM) begin
                stall_d = 1'b1;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            req_q       <= '0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            req_ready_q <= 2'b00;
            rsp_valid_q <= 2'b00;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= RESP_OKAY;
            stall_q     <= 1'b0;
            wdog_q      <= '0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
            stall_q     <= stall_d;
            wdog_q      <= wdog_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_resp  = rsp_resp_q;
    assign stall_err = stall_q;

    assign axi.ca4l_arvalid = arvalid_q;
    assign axi.ca4l_araddr  = req_q.addr;
    assign axi.ca4l_arprot  = AXI_PROT;
    assign axi.ca4l_rready   = rready_q;
    assign axi.ca4l_awvalid = awvalid_q;
    assign axi.ca4l_awaddr  = req_q.addr;
    assign axi.ca4l_awprot  = AXI_PROT;
    assign axi.ca4l_wvalid  = wvalid_q;
    assign axi.ca4l_wdata   = req_q.wdata;
    assign axi.ca4l_wstrb   = req_q.wstrb;
    assign axi.ca4l_bready  = bready_q;

endmodule

// File: tb/tb_ups_axi4l_arb.sv
// Directed bench for ups_axi4l_arb with a reactive AXI4-Lite slave and a response scoreboard.
module tb_ups_axi4l_arb;

    localparam int unsigned LIMIT = 40;
    localparam logic [2:0]  PROT  = 3'b010;

    typedef struct {
        int          idx;
        logic [31:0] rdata;
        logic [1:0]  resp;
    } exp_t;

    logic              fclk  = 1'b0;
    logic              rst_n = 1'b0;
    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [1:0]        req_wr;
    logic [1:0][31:0]  req_addr;
    logic [1:0][31:0]  req_wdata;
    logic [1:0][3:0]   req_wstrb;
    logic [1:0]        rsp_valid;
    logic [31:0]       rsp_rdata;
    logic [1:0]        rsp_resp;
    logic              stall_err;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    exp_t sb[$];
    logic gnt_log[$];
    int   gnt_cyc[$];

    // slave knobs
    int          ar_delay = 0;
    int          aw_delay = 0;
    int          w_delay  = 0;
    logic        r_hold   = 1'b0;
    logic        r_echo   = 1'b0;
    logic [31:0] r_data   = 32'h0;
    logic [1:0]  r_resp   = 2'b00;
    logic [1:0]  b_resp   = 2'b00;

    ups_axi4l_arb_if axi ();

    ups_axi4l_arb #(
        .AXI_PROT    (PROT),
        .STALL_LIMIT (LIMIT)
    ) dut (
        .fclk      (fclk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_wr    (req_wr),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wstrb (req_wstrb),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_resp  (rsp_resp),
        .stall_err (stall_err),
        .axi       (axi)
    );

    always #5 fclk = ~fclk;

    initial forever begin
        @(posedge fclk);
        cyc++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reactive slave, updated on the falling edge.
    initial begin
        int          ar_cnt;
        int          aw_cnt;
        int          w_cnt;
        logic [31:0] ar_lat;
        ar_cnt = 0; aw_cnt = 0; w_cnt = 0; ar_lat = 32'h0;
        axi.ca4l_arready = 1'b0;
        axi.ca4l_rvalid  = 1'b0;
        axi.ca4l_rdata   = 32'h0;
        axi.ca4l_rresp   = 2'b00;
        axi.ca4l_awready = 1'b0;
        axi.ca4l_wready  = 1'b0;
        axi.ca4l_bvalid  = 1'b0;
        axi.ca4l_bresp   = 2'b00;
        forever begin
            @(negedge fclk);
            if (axi.ca4l_arvalid === 1'b1) begin
                axi.ca4l_arready = (ar_cnt >= ar_delay);
                if (axi.ca4l_arready) ar_lat = axi.ca4l_araddr;
                ar_cnt++;
            end else begin
                axi.ca4l_arready = 1'b0;
                ar_cnt = 0;
            end
            if (axi.ca4l_awvalid === 1'b1) begin
                axi.ca4l_awready = (aw_cnt >= aw_delay);
                aw_cnt++;
            end else begin
                axi.ca4l_awready = 1'b0;
                aw_cnt = 0;
            end
            if (axi.ca4l_wvalid === 1'b1) begin
                axi.ca4l_wready = (w_cnt >= w_delay);
                w_cnt++;
            end else begin
                axi.ca4l_wready = 1'b0;
                w_cnt = 0;
            end
            if (axi.ca4l_rready === 1'b1 && !r_hold) begin
                axi.ca4l_rvalid = 1'b1;
                axi.ca4l_rdata  = r_echo ? (ar_lat | 32'hAB00_0000) : r_data;
                axi.ca4l_rresp  = r_resp;
            end else begin
                axi.ca4l_rvalid = 1'b0;
                axi.ca4l_rdata  = 32'h0;
            end
            axi.ca4l_bvalid = (axi.ca4l_bready === 1'b1);
            axi.ca4l_bresp  = b_resp;
        end
    end

    // Response scoreboard and grant logger.
    initial begin
        exp_t       e;
        logic [1:0] prev_ready;
        logic [1:0] ev;
        prev_ready = 2'b00;
        forever begin
            @(negedge fclk);
            if (rst_n === 1'b1) begin
                if (req_ready !== 2'b00) begin
                    chk("req_ready_onehot", 32'($countones(req_ready)), 32'd1);
                    chk("req_ready_pulse", 32'(prev_ready), 32'd0);
                    gnt_log.push_back(req_ready[1]);
                    gnt_cyc.push_back(cyc);
                end
                if (rsp_valid !== 2'b00) begin
                    if (sb.size() == 0) begin
                        chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
                    end else begin
                        e  = sb.pop_front();
                        ev = (e.idx == 1) ? 2'b10 : 2'b01;
                        chk("rsp_valid", 32'(rsp_valid), 32'(ev));
                        chk("rsp_rdata", rsp_rdata, e.rdata);
                        chk("rsp_resp", 32'(rsp_resp), 32'(e.resp));
                    end
                end
            end
            prev_ready = req_ready;
        end
    end

    // Raise one request, queue its expected response, wait for its accept pulse.
    task automatic do_req(input int idx, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] strb,
                          input logic [31:0] erd, input logic [1:0] eresp, output int lat);
        int n;
        req_wr[idx]    = wr;
        req_addr[idx]  = addr;
        req_wdata[idx] = wdata;
        req_wstrb[idx] = strb;
        req_valid[idx] = 1'b1;
        sb.push_back('{idx: idx, rdata: erd, resp: eresp});
        n = 0;
        do begin
            @(negedge fclk);
            n++;
        end while (req_ready[idx] !== 1'b1 && n < 20);
        chk("grant_seen", 32'(req_ready[idx]), 32'd1);
        req_valid[idx] = 1'b0;
        lat = n;
    endtask

    task automatic wait_sb(input string tag, input int bound);
        int n;
        n = 0;
        while (sb.size() != 0 && n < bound) begin
            @(negedge fclk);
            n++;
        end
        chk(tag, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int lat;
        int n;
        req_valid = '0;
        req_wr    = '0;
        req_addr  = '0;
        req_wdata = '0;
        req_wstrb = '0;

        // reset state
        repeat (3) @(negedge fclk);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rsp_resp", 32'(rsp_resp), 32'd0);
        chk("rst_stall", 32'(stall_err), 32'd0);
        chk("rst_arvalid", 32'(axi.ca4l_arvalid), 32'd0);
        chk("rst_awvalid", 32'(axi.ca4l_awvalid), 32'd0);
        chk("rst_wvalid", 32'(axi.ca4l_wvalid), 32'd0);
        chk("rst_rready", 32'(axi.ca4l_rready), 32'd0);
        chk("rst_bready", 32'(axi.ca4l_bready), 32'd0);
        chk("rst_araddr", axi.ca4l_araddr, 32'd0);
        chk("rst_awaddr", axi.ca4l_awaddr, 32'd0);
        chk("rst_wdata", axi.ca4l_wdata, 32'd0);
        chk("rst_wstrb", 32'(axi.ca4l_wstrb), 32'd0);
        rst_n = 1'b1;

        // read, requester 0, addr 0x4 -> 0x11/OKAY
        r_data = 32'h11;
        @(negedge fclk);
        chk("rd0_arvalid_before", 32'(axi.ca4l_arvalid), 32'd0);
        do_req(0, 1'b0, 32'h4, 32'h0, 4'h0, 32'h11, 2'b00, lat);
        chk("rd0_latency", 32'(lat), 32'd1);
        chk("rd0_arvalid", 32'(axi.ca4l_arvalid), 32'd1);
        chk("rd0_araddr", axi.ca4l_araddr, 32'h4);
        chk("rd0_arprot", 32'(axi.ca4l_arprot), 32'(PROT));
        @(negedge fclk);
        chk("rd0_arvalid_drop", 32'(axi.ca4l_arvalid), 32'd0);
        chk("rd0_rready", 32'(axi.ca4l_rready), 32'd1);
        wait_sb("rd0_done", 10);

        // write, requester 1, awready two cycles ahead of wready
        aw_delay = 0;
        w_delay  = 2;
        @(negedge fclk);
        do_req(1, 1'b1, 32'h8, 32'hC38D, 4'hF, 32'h0, 2'b00, lat);
        chk("wr1_awvalid", 32'(axi.ca4l_awvalid), 32'd1);
        chk("wr1_wvalid", 32'(axi.ca4l_wvalid), 32'd1);
        chk("wr1_awaddr", axi.ca4l_awaddr, 32'h8);
        chk("wr1_wdata", axi.ca4l_wdata, 32'hC38D);
        chk("wr1_wstrb", 32'(axi.ca4l_wstrb), 32'hF);
        chk("wr1_awprot", 32'(axi.ca4l_awprot), 32'(PROT));
        @(negedge fclk);
        chk("wr1_aw_first", 32'(axi.ca4l_awvalid), 32'd0);
        chk("wr1_w_held1", 32'(axi.ca4l_wvalid), 32'd1);
        chk("wr1_bready_early", 32'(axi.ca4l_bready), 32'd0);
        @(negedge fclk);
        chk("wr1_w_held2", 32'(axi.ca4l_wvalid), 32'd1);
        @(negedge fclk);
        chk("wr1_w_drop", 32'(axi.ca4l_wvalid), 32'd0);
        chk("wr1_bready", 32'(axi.ca4l_bready), 32'd1);
        wait_sb("wr1_done", 10);
        w_delay = 0;

        // both requesters continuously valid: 0,1,0,1
        r_echo = 1'b1;
        gnt_log.delete();
        gnt_cyc.delete();
        @(negedge fclk);
        req_wr       = 2'b00;
        req_addr[0]  = 32'h100;
        req_addr[1]  = 32'h200;
        sb.push_back('{idx: 0, rdata: 32'hAB00_0100, resp: 2'b00});
        sb.push_back('{idx: 1, rdata: 32'hAB00_0200, resp: 2'b00});
        sb.push_back('{idx: 0, rdata: 32'hAB00_0100, resp: 2'b00});
        sb.push_back('{idx: 1, rdata: 32'hAB00_0200, resp: 2'b00});
        req_valid = 2'b11;
        n = 0;
        while (gnt_log.size() < 4 && n < 100) begin
            @(negedge fclk);
            n++;
        end
        req_valid = 2'b00;
        chk("rr_grant_count", 32'(gnt_log.size()), 32'd4);
        if (gnt_log.size() >= 4) begin
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("rr_grant%0d", i), 32'(gnt_log[i]), 32'(i % 2));
            end
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("rr_spacing%0d", i), 32'(gnt_cyc[i+1] - gnt_cyc[i]), 32'd4);
            end
        end
        wait_sb("rr_done", 30);
        r_echo = 1'b0;

        // error responses pass through, watchdog untouched
        b_resp = 2'b10;
        @(negedge fclk);
        do_req(0, 1'b1, 32'h40, 32'hDEAD_BEEF, 4'h3, 32'h0, 2'b10, lat);
        wait_sb("slverr_done", 10);
        chk("slverr_stall", 32'(stall_err), 32'd0);
        b_resp = 2'b00;
        r_resp = 2'b11;
        r_data = 32'h77;
        @(negedge fclk);
        do_req(1, 1'b0, 32'h44, 32'h0, 4'h0, 32'h77, 2'b11, lat);
        wait_sb("decerr_done", 10);
        chk("decerr_stall", 32'(stall_err), 32'd0);
        r_resp = 2'b00;

        // arready withheld for LIMIT cycles
        ar_delay = LIMIT;
        r_data   = 32'h5A5A;
        @(negedge fclk);
        do_req(0, 1'b0, 32'hC, 32'h0, 4'h0, 32'h5A5A, 2'b00, lat);
        chk("stall_at0", 32'(stall_err), 32'd0);
        for (int k = 1; k <= LIMIT; k++) begin
            @(negedge fclk);
            if (k == LIMIT - 1) chk("stall_pre", 32'(stall_err), 32'd0);
            if (k == LIMIT) begin
                chk("stall_rise", 32'(stall_err), 32'd1);
                chk("stall_arvalid_held", 32'(axi.ca4l_arvalid), 32'd1);
                chk("stall_araddr_held", axi.ca4l_araddr, 32'hC);
            end
        end
        wait_sb("stall_done", 10);
        chk("stall_after_done", 32'(stall_err), 32'd1);
        repeat (3) @(negedge fclk);
        chk("stall_sticky", 32'(stall_err), 32'd1);
        ar_delay = 0;

        // reset while waiting in RD_DATA
        r_hold = 1'b1;
        @(negedge fclk);
        do_req(1, 1'b0, 32'h20, 32'h0, 4'h0, 32'h0, 2'b00, lat);
        n = 0;
        while (axi.ca4l_rready !== 1'b1 && n < 10) begin
            @(negedge fclk);
            n++;
        end
        chk("mid_rready_seen", 32'(axi.ca4l_rready), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_arvalid", 32'(axi.ca4l_arvalid), 32'd0);
        chk("mid_rst_rready", 32'(axi.ca4l_rready), 32'd0);
        chk("mid_rst_stall", 32'(stall_err), 32'd0);
        sb.delete();
        for (int k = 0; k < 3; k++) begin
            @(negedge fclk);
            chk("mid_rst_no_rsp", 32'(rsp_valid), 32'd0);
        end
        r_hold = 1'b0;
        rst_n  = 1'b1;

        // first tie after reset goes to requester 0
        r_echo = 1'b1;
        gnt_log.delete();
        req_wr      = 2'b00;
        req_addr[0] = 32'h300;
        req_addr[1] = 32'h400;
        sb.push_back('{idx: 0, rdata: 32'hAB00_0300, resp: 2'b00});
        req_valid = 2'b11;
        n = 0;
        do begin
            @(negedge fclk);
            n++;
        end while (req_ready === 2'b00 && n < 20);
        req_valid = 2'b00;
        chk("post_rst_grant", 32'(req_ready), 32'd1);
        wait_sb("post_rst_done", 10);
        repeat (3) @(negedge fclk);
        chk("post_rst_idle", 32'(axi.ca4l_arvalid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
